// File: rtl/mem_wb_stage.sv
// MEM/WB stage: data-memory access with WAIT_STATES wait cycles, stall generation, MEM/WB result register.
// Optional MEM_ALIGN_CHECK_EN: flags misaligned loads/stores via misalign_out instead of accessing memory.
module mem_wb_stage #(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_wb_wb_in,
  input  logic [1:0]  mem_wb_mem_in,
  input  logic [31:0] mem_wb_alu_res_in,
  input  logic [31:0] mem_wb_rt_in,
  input  logic [4:0]  mem_wb_reg_dest_in,
  output logic        stall_out,
  output logic [1:0]  mem_wb_wb_out,
  output logic [31:0] mem_wb_mem_data_out,
  output logic [31:0] mem_wb_alu_res_out,
  output logic [4:0]  mem_wb_reg_dest_out
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_out
`endif
);

  localparam int ADDR_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMPLETE} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [31:0] mem [MEM_WORDS];
  logic [ADDR_W-1:0] idx;
  logic [31:0] rd_data;
  logic access, rd, wr, mis, valid_access;
  logic commit, write_en;
  logic unused_addr_bits;

  assign access = mem_wb_mem_in[1] | mem_wb_mem_in[0];
  // A simultaneous read+write request is a read; the write half is dropped.
  assign rd     = mem_wb_mem_in[1];
  assign wr     = mem_wb_mem_in[0] & ~mem_wb_mem_in[1];
  assign idx    = mem_wb_alu_res_in[ADDR_W+1:2];
  assign rd_data = mem[idx];
  assign unused_addr_bits = ^{mem_wb_alu_res_in[31:ADDR_W+2], mem_wb_alu_res_in[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = access & (|mem_wb_alu_res_in[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign valid_access = access & ~mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (valid_access && WAIT_STATES > 0) begin
          cnt_nxt   = 4'(WAIT_STATES - 1);
          state_nxt = (WAIT_STATES == 1) ? S_COMPLETE : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_COMPLETE;
      end
      S_COMPLETE: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stall_out = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        stall_out = valid_access && (WAIT_STATES > 0);
        commit    = !(valid_access && (WAIT_STATES > 0));
      end
      S_WAIT:     stall_out = 1'b1;
      S_COMPLETE: commit    = 1'b1;
      default:    commit    = 1'b0;
    endcase
  end

  // Gated by rst so a reset landing on the completion edge aborts the store.
  assign write_en = commit & wr & ~mis & ~rst;

  always_ff @(posedge clk) begin
    if (write_en) mem[idx] <= mem_wb_rt_in;
  end

  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst || !commit) begin
      mem_wb_wb_out       <= 2'b00;
      mem_wb_mem_data_out <= 32'd0;
      mem_wb_alu_res_out  <= 32'd0;
      mem_wb_reg_dest_out <= 5'd0;
      misalign_q          <= 1'b0;
    end else begin
      mem_wb_wb_out       <= mis ? 2'b00 : mem_wb_wb_in;
      mem_wb_mem_data_out <= (rd && !mis) ? rd_data : 32'd0;
      mem_wb_alu_res_out  <= mem_wb_alu_res_in;
      mem_wb_reg_dest_out <= mem_wb_reg_dest_in;
      misalign_q          <= mis;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_out = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EXE/MEM pipeline interface in the 5-stage MIPS pipeline.
- Takes the EXE/MEM register outputs, performs the data-memory access and registers the MEM/WB results for writeback.
- Data memory is internal and word-addressed, with a configurable number of wait states.
- Asserts a stall back to the earlier stages while a multi-cycle access is in progress.

Parameters:
- MEM_WORDS, 256, data memory depth in 32-bit words (power of 2); ADDR_W = log2(MEM_WORDS).
- WAIT_STATES, 2, extra cycles per load/store (0..15); 0 gives a single-cycle access.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- mem_wb_wb_in  in  2  [1]=reg_write, [0]=mem_to_reg.
- mem_wb_mem_in  in  2  [1]=mem_read, [0]=mem_write.
- mem_wb_alu_res_in  in  32  ALU result / byte address.
- mem_wb_rt_in  in  32  store data.
- mem_wb_reg_dest_in  in  5  destination register.
- stall_out  out  1  upstream must hold its inputs stable while high.
- mem_wb_wb_out  out  2  registered wb control.
- mem_wb_mem_data_out  out  32  registered load data.
- mem_wb_alu_res_out  out  32  registered ALU result.
- mem_wb_reg_dest_out  out  5  registered destination.
- misalign_out  out  1  only with MEM_ALIGN_CHECK_EN; registered misaligned-access flag.

Behaviour:
- Reset, sampled on posedge clk: every output is 0, FSM = IDLE, wait counter = 0. Memory contents are not cleared.
- Access definition:
  - access = mem_read | mem_write.
  - mem_in = 2'b11 is treated as a read; the write is suppressed.
- Word index: alu_res_in[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo MEM_WORDS*4. Bits [1:0] are ignored unless the optional feature is compiled in.
- Memory read is combinational from the array; the result is captured only at the completion edge.
- Non-access instruction in IDLE:
  - Behaves as a plain pipeline register with 1-cycle latency.
  - On the next edge, wb/alu_res/reg_dest are copied through and mem_data_out is loaded with 0.
  - stall_out = 0.
- Access with WAIT_STATES = W > 0, inputs first presented in cycle t (FSM in IDLE):
  - stall_out is combinationally high in cycles t..t+W-1 (exactly W cycles) and low in cycle t+W.
  - FSM: IDLE -> WAIT on the edge ending cycle t, counter loaded with W-1. In WAIT the counter decrements each edge. At counter = 0 the state is COMPLETE for cycle t+W, and the FSM returns to IDLE on the edge ending t+W.
  - Edges ending t..t+W-1 load a bubble: wb_out = 00, reg_dest_out = 0, alu_res_out = 0, mem_data_out = 0.
  - Edge ending t+W commits the access:
    - A write stores rt_in.
    - A read captures mem[index] into mem_data_out.
    - wb/alu_res/reg_dest are registered.
    - Results are visible in cycle t+W+1.
  - Total latency is W+1 cycles. Exactly one write occurs per store.
- W = 0: the access completes in one cycle with no stall, identical in timing to a non-access instruction.
- Back-to-back accesses: a new access presented in the cycle after completion starts a fresh W-cycle stall. There is no idle gap.
- Load following a store to the same index: the load returns the stored data, because the write committed on an earlier edge.
- Inputs changing while stall_out is high is a protocol violation with unspecified result; the bench asserts stability instead.
- Reset during WAIT: the access is aborted and no write is committed. FSM returns to IDLE, and stall_out is 0 in the cycle after the reset edge.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - An access with alu_res_in[1:0] != 0 is misaligned. It completes with no stall, and memory is neither written nor read.
  - On the next edge, wb_out is forced to 00 and misalign_out = 1 for one cycle.
  - Non-access instructions ignore alignment.
- Undefined: the misalign_out port does not exist and the low address bits are ignored.

Test Plan:
- Reset: after rst high for 2 edges, all outputs 0 and stall_out 0; rst held mid-WAIT (W=2) -> no write committed (later load of that word returns its prior value), stall_out low next cycle.
- ALU-only: wb=10, mem=00, alu_res=0x0000_1234, reg_dest=5 -> one cycle later wb_out=10, alu_res_out=0x1234, reg_dest_out=5, mem_data_out=0, no stall.
- Store then load, W=2:
  - sw of rt=0xDEADBEEF to address 0x10 -> stall_out high 2 cycles, bubbles (wb_out=00) during the stall.
  - Next lw from 0x10 with wb=11, reg_dest=8 -> 2-cycle stall, then mem_data_out=0xDEADBEEF, wb_out=11, reg_dest_out=8.
- Wrap and back-to-back, MEM_WORDS=256:
  - Store 0xA5A5A5A5 to 0x400 -> lands in word 0; immediate load from 0x000 returns 0xA5A5A5A5.
  - The two accesses show consecutive 2-cycle stalls.
- W=0 build: load/store sequence completes with stall_out always 0 and 1-cycle latency.
- MEM_ALIGN_CHECK_EN: sw to 0x13 -> no stall, misalign_out=1 for one cycle, wb_out=00; subsequent lw from 0x10 returns the previous contents unchanged.
